tpg_source: RTL and testbench

- Traffic pattern generator for the NoC BFM set. Transmit-side counterpart of the per-node traffic sink; one instance sits at each router's input port.
- Emits packets in the same field layout the sink decodes: {src, dst, id, seq}.
- Uses a valid/ready handshake. Supports configurable destination pattern, packet count and inter-packet gap.

---
 rtl/lynx_bfm_pkg.sv | 32 +++
 rtl/tpg_dst_seq.sv | 60 ++++++
 rtl/tpg_source.sv | 169 ++++++++++++++++
 tb/tb_tpg_source.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/lynx_bfm_pkg.sv
// Shared definitions for the lynx NoC BFM set: packet field layout helpers,
// generator FSM states and destination-mode encodings.
package lynx_bfm_pkg;

   localparam int DST_FIXED = 0;
   localparam int DST_RR    = 1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SEND     = 2'd1,
      WAIT_GAP = 2'd2,
      DONE     = 2'd3
   } tpg_state_e;

   // Packet layout, MSB first: {src, dst, id[7:0], seq}
   function automatic int seq_width(input int width, input int aw);
      return width - 2 * aw - 8;
   endfunction

   function automatic int src_lsb(input int width, input int aw);
      return width - aw;
   endfunction

   function automatic int dst_lsb(input int width, input int aw);
      return width - 2 * aw;
   endfunction

   function automatic int id_lsb(input int width, input int aw);
      return width - 2 * aw - 8;
   endfunction

endpackage

// File: rtl/tpg_dst_seq.sv
// Destination pointer for the traffic generator: fixed destination, or
// round-robin over every node except our own.
module tpg_dst_seq
   import lynx_bfm_pkg::*;
#(
   parameter int N            = 16,
   parameter int N_ADDR_WIDTH = $clog2(N),
   parameter int NODE         = 0,
   parameter int DST_MODE     = DST_FIXED,
   parameter int DEST         = N - 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    advance,
   output logic [N_ADDR_WIDTH-1:0] dst
);

   localparam logic [N_ADDR_WIDTH-1:0] NODE_A  = N_ADDR_WIDTH'(NODE);
   localparam logic [N_ADDR_WIDTH-1:0] LAST_A  = N_ADDR_WIDTH'(N - 1);
   localparam logic [N_ADDR_WIDTH-1:0] FIRST_A = N_ADDR_WIDTH'((NODE + 1) % N);
   localparam logic [N_ADDR_WIDTH-1:0] RESET_A =
      (DST_MODE == DST_RR) ? FIRST_A : N_ADDR_WIDTH'(DEST);

   if (DST_MODE == DST_RR && N < 2) begin : g_bad_rr
      $error("tpg_dst_seq: round-robin destination needs N >= 2");
   end

   logic [N_ADDR_WIDTH-1:0] dst_q, dst_d, inc_s, nxt_s;

   // Next round-robin target, wrapping mod N and stepping over our own node
   always_comb begin
      if (dst_q != LAST_A) begin
         inc_s = dst_q + N_ADDR_WIDTH'(1);
      end else begin
         inc_s = '0;
      end
      if (inc_s == NODE_A) begin
         nxt_s = FIRST_A;
      end else begin
         nxt_s = inc_s;
      end
      if (advance && DST_MODE == DST_RR) begin
         dst_d = nxt_s;
      end else begin
         dst_d = dst_q;
      end
   end

   // Pointer register
   always_ff @(posedge clk) begin
      if (rst) begin
         dst_q <= RESET_A;
      end else begin
         dst_q <= dst_d;
      end
   end

   assign dst = dst_q;

endmodule

// File: rtl/tpg_source.sv
// NoC traffic pattern generator: emits {src, dst, id, seq} packets over a
// valid/ready handshake with optional packet limit and inter-packet gap.
module tpg_source
   import lynx_bfm_pkg::*;
#(
   parameter int         WIDTH        = 32,
   parameter int         N            = 16,
   parameter int         N_ADDR_WIDTH = $clog2(N),
   parameter logic [7:0] ID           = 8'd0,
   parameter int         NODE         = 0,
   parameter int         DST_MODE     = DST_FIXED,
   parameter int         DEST         = N - 1,
   parameter int         NUM_PACKETS  = 0,
   parameter int         GAP          = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   output logic [WIDTH-1:0] data_out,
   output logic             valid_out,
   input  logic             ready_in,
   output logic             done,
   output logic [31:0]      sent_count
);

   localparam int SEQW    = seq_width(WIDTH, N_ADDR_WIDTH);
   localparam int SRC_LSB = src_lsb(WIDTH, N_ADDR_WIDTH);
   localparam int DST_LSB = dst_lsb(WIDTH, N_ADDR_WIDTH);
   localparam int ID_LSB  = id_lsb(WIDTH, N_ADDR_WIDTH);

   if (SEQW < 1) begin : g_bad_seqw
      $error("tpg_source: WIDTH too small, sequence field would be empty");
   end

   tpg_state_e              state_q, state_d;
   logic [WIDTH-1:0]        data_q, data_d, pkt_s;
   logic                    valid_q, valid_d;
   logic                    done_q, done_d;
   logic [31:0]             cnt_q, cnt_d;
   logic [31:0]             gap_q, gap_d;
   logic [SEQW-1:0]         seq_q, seq_d;
   logic [N_ADDR_WIDTH-1:0] dst_s;
   logic                    load_s, xfer_s, limit_s;

   // The pointer steps when a packet is loaded, so it always holds the
   // destination of the next packet to be presented (back-to-back safe).
   tpg_dst_seq #(
      .N            (N),
      .N_ADDR_WIDTH (N_ADDR_WIDTH),
      .NODE         (NODE),
      .DST_MODE     (DST_MODE),
      .DEST         (DEST)
   ) u_dst_seq (
      .clk     (clk),
      .rst     (rst),
      .advance (load_s),
      .dst     (dst_s)
   );

   // Assemble the packet that would be launched this cycle
   always_comb begin
      pkt_s = '0;
      pkt_s[SRC_LSB +: N_ADDR_WIDTH] = N_ADDR_WIDTH'(NODE);
      pkt_s[DST_LSB +: N_ADDR_WIDTH] = dst_s;
      pkt_s[ID_LSB +: 8]             = ID;
      pkt_s[SEQW-1:0]                = seq_q;
   end

   assign xfer_s  = valid_q && ready_in;
   assign limit_s = (NUM_PACKETS != 0) && (cnt_q >= 32'(NUM_PACKETS));

   // Next-state and output logic
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      valid_d = valid_q;
      done_d  = done_q;
      cnt_d   = cnt_q;
      gap_d   = gap_q;
      seq_d   = seq_q;
      load_s  = 1'b0;
      case (state_q)
         IDLE: begin
            valid_d = 1'b0;
            if (enable && !limit_s) begin
               load_s = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         SEND: begin
            if (xfer_s) begin
               cnt_d = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
               if (NUM_PACKETS != 0 && cnt_q + 32'd1 == 32'(NUM_PACKETS)) begin
                  valid_d = 1'b0;
                  done_d  = 1'b1;
                  state_d = DONE;
               end else if (GAP > 0) begin
                  valid_d = 1'b0;
                  gap_d   = 32'(GAP);
                  state_d = WAIT_GAP;
               end else if (enable) begin
                  load_s = 1'b1;
               end else begin
                  valid_d = 1'b0;
                  state_d = IDLE;
               end
            end else begin
               valid_d = 1'b1;
            end
         end
         WAIT_GAP: begin
            valid_d = 1'b0;
            if (gap_q <= 32'd1) begin
               if (enable) begin
                  load_s = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               gap_d = gap_q - 32'd1;
            end
         end
         DONE: begin
            valid_d = 1'b0;
            done_d  = 1'b1;
         end
         default: begin
            valid_d = 1'b0;
            state_d = IDLE;
         end
      endcase
      if (load_s) begin
         data_d  = pkt_s;
         valid_d = 1'b1;
         seq_d   = seq_q + SEQW'(1);
         state_d = SEND;
      end else begin
         seq_d = seq_q;
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         data_q  <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= 32'd0;
         gap_q   <= 32'd0;
         seq_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
         seq_q   <= seq_d;
      end
   end

   assign data_out   = data_q;
   assign valid_out  = valid_q;
   assign done       = done_q;
   assign sent_count = cnt_q;

endmodule

// File: tb/tb_tpg_source.sv
// Directed self-checking bench for tpg_source: burst, backpressure, gap,
// round-robin destinations and sequence wrap with mid-transfer reset.
module tb_tpg_source;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // burst / backpressure instance
   logic        en_a = 1'b0, rdy_a = 1'b0, val_a, done_a;
   logic [31:0] dat_a, cnt_a;
   // gap instance
   logic        en_b = 1'b0, rdy_b = 1'b0, val_b, done_b;
   logic [31:0] dat_b, cnt_b;
   // round-robin instance
   logic        en_c = 1'b0, rdy_c = 1'b0, val_c, done_c;
   logic [31:0] dat_c, cnt_c;
   // narrow (SEQW=4) instance
   logic        en_d = 1'b0, rdy_d = 1'b0, val_d, done_d;
   logic [19:0] dat_d;
   logic [31:0] cnt_d;

   tpg_source #(.WIDTH(32), .N(16), .ID(8'd5), .NODE(3), .DST_MODE(0), .DEST(12),
                .NUM_PACKETS(4), .GAP(0)) u_a (
      .clk(clk), .rst(rst), .enable(en_a), .data_out(dat_a), .valid_out(val_a),
      .ready_in(rdy_a), .done(done_a), .sent_count(cnt_a));

   tpg_source #(.WIDTH(32), .N(16), .ID(8'd5), .NODE(3), .DST_MODE(0), .DEST(12),
                .NUM_PACKETS(0), .GAP(2)) u_b (
      .clk(clk), .rst(rst), .enable(en_b), .data_out(dat_b), .valid_out(val_b),
      .ready_in(rdy_b), .done(done_b), .sent_count(cnt_b));

   tpg_source #(.WIDTH(32), .N(16), .ID(8'd5), .NODE(3), .DST_MODE(1), .DEST(12),
                .NUM_PACKETS(0), .GAP(0)) u_c (
      .clk(clk), .rst(rst), .enable(en_c), .data_out(dat_c), .valid_out(val_c),
      .ready_in(rdy_c), .done(done_c), .sent_count(cnt_c));

   tpg_source #(.WIDTH(20), .N(16), .ID(8'd5), .NODE(3), .DST_MODE(0), .DEST(12),
                .NUM_PACKETS(0), .GAP(0)) u_d (
      .clk(clk), .rst(rst), .enable(en_d), .data_out(dat_d), .valid_out(val_d),
      .ready_in(rdy_d), .done(done_d), .sent_count(cnt_d));

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int          rr_dst [16] = '{4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 0, 1, 2, 4};
   logic [31:0] exp_w;

   initial begin
      tick();
      tick();
      check_eq("rst_valid", {31'd0, val_a}, 32'd0);
      check_eq("rst_data",  dat_a, 32'd0);
      check_eq("rst_done",  {31'd0, done_a}, 32'd0);
      check_eq("rst_cnt",   cnt_a, 32'd0);
      rst = 1'b0;

      // basic burst of four back-to-back packets
      en_a = 1'b1; rdy_a = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check_eq("burst_valid", {31'd0, val_a}, 32'd1);
         check_eq("burst_data",  dat_a, 32'h3C05_0000 + 32'(k));
      end
      tick();
      check_eq("burst_done",   {31'd0, done_a}, 32'd1);
      check_eq("burst_vlow",   {31'd0, val_a}, 32'd0);
      check_eq("burst_cnt",    cnt_a, 32'd4);
      tick();
      check_eq("done_sticky",  {31'd0, done_a}, 32'd1);
      check_eq("done_novalid", {31'd0, val_a}, 32'd0);

      // backpressure: held stable even while enable drops
      rst = 1'b1; en_a = 1'b0; rdy_a = 1'b0;
      tick();
      rst = 1'b0;
      check_eq("rst2_done", {31'd0, done_a}, 32'd0);
      en_a = 1'b1;
      tick();
      check_eq("bp_first_v", {31'd0, val_a}, 32'd1);
      check_eq("bp_first_d", dat_a, 32'h3C05_0000);
      en_a = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check_eq("bp_hold_v", {31'd0, val_a}, 32'd1);
         check_eq("bp_hold_d", dat_a, 32'h3C05_0000);
         check_eq("bp_hold_c", cnt_a, 32'd0);
      end
      rdy_a = 1'b1;
      tick();
      check_eq("bp_acc_cnt", cnt_a, 32'd1);
      check_eq("bp_idle_v",  {31'd0, val_a}, 32'd0);
      en_a = 1'b1;
      tick();
      check_eq("bp_next_v",  {31'd0, val_a}, 32'd1);
      check_eq("bp_next_d",  dat_a, 32'h3C05_0001);
      en_a = 1'b0; rdy_a = 1'b0;

      // gap of two idle cycles between accepts
      en_b = 1'b1; rdy_b = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick();
         check_eq("gap_valid", {31'd0, val_b}, (i % 3 == 0) ? 32'd1 : 32'd0);
         if (i % 3 == 0) check_eq("gap_data", dat_b, 32'h3C05_0000 + 32'(i / 3));
      end
      en_b = 1'b0; rdy_b = 1'b0;

      // round-robin destinations skipping node 3
      en_c = 1'b1; rdy_c = 1'b1;
      for (int k = 0; k < 16; k++) begin
         tick();
         exp_w = {4'd3, 4'(rr_dst[k]), 8'h05, 16'(k)};
         check_eq("rr_data", dat_c, exp_w);
      end
      en_c = 1'b0; rdy_c = 1'b0;

      // 4-bit sequence wrap, then reset while stalled
      en_d = 1'b1; rdy_d = 1'b1;
      for (int k = 0; k < 17; k++) begin
         tick();
         if (k == 15) check_eq("wrap_seq15", {12'd0, dat_d}, 32'h0003_C05F);
      end
      check_eq("wrap_seq0", {12'd0, dat_d}, 32'h0003_C050);
      tick();
      check_eq("wrap_cnt17", cnt_d, 32'd17);
      check_eq("wrap_v18",   {31'd0, val_d}, 32'd1);
      rdy_d = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("mid_rst_v", {31'd0, val_d}, 32'd0);
      check_eq("mid_rst_c", cnt_d, 32'd0);
      check_eq("mid_rst_d", {12'd0, dat_d}, 32'd0);
      rdy_d = 1'b1;
      tick();
      check_eq("post_rst_v", {31'd0, val_d}, 32'd1);
      check_eq("post_rst_d", {12'd0, dat_d}, 32'h0003_C050);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
